// File: rtl/display_scan_mux_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// Contents: digit count, BCD limit, scan state enum, digit type, and a
// leading-zero mask helper used when DISPLAY_SCAN_LZB_EN is defined.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Bit k set when digit k and every digit above it are zero.
  // Digit 0 is never flagged.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input bcd_digit_t [NUM_DIGITS-1:0] d
  );
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (d[k] == 4'd0);
      lz_mask[k] = zero_above;
    end
  endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Bus between the digit source and the scan driver.
// Source side: digits_i, dp_i, upd_i. Display side: bcd_o, an_o (active low),
// dp_n_o (active low), frame_o. master = digit source, slave = scan driver.
interface display_scan_mux_if;
  import display_pkg::*;

  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        upd_i;
  bcd_digit_t  bcd_o;
  logic [3:0]  an_o;
  logic        dp_n_o;
  logic        frame_o;

  modport master (
    output digits_i, dp_i, upd_i,
    input  bcd_o, an_o, dp_n_o, frame_o
  );

  modport slave (
    input  digits_i, dp_i, upd_i,
    output bcd_o, an_o, dp_n_o, frame_o
  );

endinterface

// File: rtl/display_refresh_timer.sv
// Digit-period counter for the scan driver: counts 0..REFRESH_DIV-1 and wraps.
// Ports: clk, reset (async, active high); tc = last cycle of the period,
// guard_end = last cycle of the all-anodes-off guard interval.
module display_refresh_timer #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tc,
  output logic guard_end
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tc        = (cnt == LAST_CNT);
  assign guard_end = (cnt == GUARD_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Ports: clk, reset (async, active high), bus (slave): digits/dp/upd in,
// bcd/an/dp_n/frame out, all outputs registered one cycle after state/idx.
// Build option: define DISPLAY_SCAN_LZB_EN for leading-zero blanking.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  display_scan_mux_if.slave bus
);

  logic tc;
  logic guard_end;

  display_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tc       (tc),
    .guard_end(guard_end)
  );

  scan_state_t                   state_q, state_d;
  logic [1:0]                    idx_q;
  bcd_digit_t [NUM_DIGITS-1:0]   shadow_q;
  logic [NUM_DIGITS-1:0]         shadow_dp_q;
  bcd_digit_t [NUM_DIGITS-1:0]   staging_q;
  logic [NUM_DIGITS-1:0]         staging_dp_q;
  logic                          pending_q;

  logic                          frame_boundary;
  bcd_digit_t                    sel_digit;
  logic                          sel_dp;
  logic                          sel_valid;
  logic                          sel_blank;

  bcd_digit_t                    bcd_d;
  logic [3:0]                    an_d;
  logic                          dp_n_d;

  assign frame_boundary = tc && (idx_q == 2'd3);

  assign sel_digit = shadow_q[idx_q];
  assign sel_dp    = shadow_dp_q[idx_q];
  assign sel_valid = (sel_digit <= BCD_MAX);

`ifdef DISPLAY_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] blank_mask;
  assign blank_mask = lz_mask(shadow_q);
  assign sel_blank  = blank_mask[idx_q];
`else
  assign sel_blank  = 1'b0;
`endif

  // Digit index steps once per period; wraps naturally at 2 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= 2'd0;
    end else if (tc) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Update buffering: staging collects the latest request, shadow only moves
  // at a frame boundary so a frame never mixes old and new digits. A request
  // landing on the boundary itself goes straight to shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      staging_q    <= '0;
      staging_dp_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (bus.upd_i) begin
        staging_q    <= bus.digits_i;
        staging_dp_q <= bus.dp_i;
      end
      if (frame_boundary) begin
        if (bus.upd_i) begin
          shadow_q    <= bus.digits_i;
          shadow_dp_q <= bus.dp_i;
        end else if (pending_q) begin
          shadow_q    <= staging_q;
          shadow_dp_q <= staging_dp_q;
        end
        pending_q <= 1'b0;
      end else if (bus.upd_i) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GUARD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = 4'd0;
    an_d    = 4'hF;
    dp_n_d  = 1'b1;

    case (state_q)
      GUARD:   if (guard_end) state_d = SHOW;
      SHOW:    if (tc)        state_d = GUARD;
      default: state_d = GUARD;
    endcase
    // Every period starts in guard, whatever the current state.
    if (tc) state_d = GUARD;

    // Codes above 9 are undefined downstream, so they are never forwarded.
    // A blanked leading zero is also 0, so no extra masking is needed.
    if (sel_valid) bcd_d = sel_digit;

    // A blanked digit keeps its anode only to light a requested point.
    if (state_q == SHOW && sel_valid && (!sel_blank || sel_dp)) begin
      an_d = ~(4'b0001 << idx_q);
    end
    if (state_q == SHOW && sel_valid && sel_dp) begin
      dp_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bcd_o   <= 4'd0;
      bus.an_o    <= 4'hF;
      bus.dp_n_o  <= 1'b1;
      bus.frame_o <= 1'b0;
    end else begin
      bus.bcd_o   <= bcd_d;
      bus.an_o    <= an_d;
      bus.dp_n_o  <= dp_n_d;
      bus.frame_o <= frame_boundary;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux with REFRESH_DIV=8, GUARD_CYCLES=2.
// Timeline reference: t=0 is the cycle frame_o is high; digit k SHOW outputs
// are visible at t=8k+3..8k+8, guard (anodes off) at t=8k+1..8k+2.
module tb_display_scan_mux;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  display_scan_mux_if bus();

  display_scan_mux #(
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [15:0] bcd;   // nibble k: expected bcd_o for digit k
    logic [15:0] an;    // nibble k: expected an_o during digit k SHOW
    logic [3:0]  dpn;   // bit k: expected dp_n_o during digit k SHOW
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one upd_i strobe starting at the current negedge; returns one cycle later.
  task automatic pulse_upd(input logic [15:0] d, input logic [3:0] p);
    bus.digits_i = d;
    bus.dp_i     = p;
    bus.upd_i    = 1'b1;
    @(negedge clk);
    bus.upd_i    = 1'b0;
  endtask

  // Checks the current cycle first, then waits up to 100 cycles.
  task automatic wait_frame();
    int i = 0;
    while (bus.frame_o !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("frame_wait", {15'd0, bus.frame_o}, 16'd1);
  endtask

  initial begin
    int n;
    int cur;
    int j;
    logic [3:0]  exp_an;
    logic [15:0] tmp;

    vecs[0] = '{16'h1234, 4'b0000, 16'h1234, 16'h7BDE, 4'b1111};
    vecs[1] = '{16'h5678, 4'b0001, 16'h5678, 16'h7BDE, 4'b1110};
    vecs[2] = '{16'h00A5, 4'b0100, 16'h0005, 16'h7BFE, 4'b1011};
    vecs[3] = '{16'h9F09, 4'b1010, 16'h9009, 16'h7FDE, 4'b0101};
`ifdef DISPLAY_SCAN_LZB_EN
    vecs[2].an = 16'hFBFE;
    vecs[4] = '{16'h0007, 4'b0000, 16'h0007, 16'hFFFE, 4'b1111};
    vecs[5] = '{16'h0000, 4'b0000, 16'h0000, 16'hFFFE, 4'b1111};
`else
    vecs[4] = '{16'h0007, 4'b0000, 16'h0007, 16'h7BDE, 4'b1111};
    vecs[5] = '{16'h0000, 4'b0000, 16'h0000, 16'h7BDE, 4'b1111};
`endif

    reset        = 1'b1;
    bus.digits_i = 16'h0000;
    bus.dp_i     = 4'h0;
    bus.upd_i    = 1'b0;

    // Reset state
    tick(2);
    chk("rst_an",    {12'd0, bus.an_o},   16'h000F);
    chk("rst_bcd",   {12'd0, bus.bcd_o},  16'h0000);
    chk("rst_dpn",   {15'd0, bus.dp_n_o}, 16'h0001);
    chk("rst_frame", {15'd0, bus.frame_o}, 16'h0000);

    // First anode GUARD_CYCLES+1 cycles after release, on digit 0
    reset = 1'b0;
    tick(2);
    chk("rel_guard_an", {12'd0, bus.an_o}, 16'h000F);
    tick(1);
    chk("rel_first_an", {12'd0, bus.an_o}, 16'h000E);

    // Frame period
    wait_frame();
    tick(1);
    n = 1;
    while (bus.frame_o !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    chk("frame_period", n[15:0], 16'd32);

    // Load 1234, then walk digit 0 on/off window into digit 1
    tick(3);
    pulse_upd(16'h1234, 4'b0000);
    wait_frame();
    tmp = 16'h1234;
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      j = t - 3;
      exp_an = 4'hF;
      if (j >= 0 && (j % 8) < 6) exp_an = ~(4'b0001 << (j / 8));
      chk($sformatf("win_an_t%0d", t), {12'd0, bus.an_o}, {12'd0, exp_an});
      if (exp_an != 4'hF)
        chk($sformatf("win_bcd_t%0d", t), {12'd0, bus.bcd_o}, {12'd0, tmp[4*(j/8) +: 4]});
    end

    // Mid-frame update (idx=1): current frame untouched, next frame new
    pulse_upd(16'h5678, 4'b0000);          // now t=13
    chk("mid_d1", {12'd0, bus.bcd_o}, 16'd3);
    tick(8);
    chk("mid_d2", {12'd0, bus.bcd_o}, 16'd2);
    tick(8);
    chk("mid_d3", {12'd0, bus.bcd_o}, 16'd1);
    wait_frame();
    tick(5);
    chk("next_d0", {12'd0, bus.bcd_o}, 16'd8);
    tick(8);
    chk("next_d1", {12'd0, bus.bcd_o}, 16'd7);

    // Update on the exact frame boundary (tc with idx==3)
    tick(18);                              // t=31
    pulse_upd(16'h4321, 4'b0000);          // t=32, new frame
    chk("bnd_frame", {15'd0, bus.frame_o}, 16'd1);
    tick(5);
    chk("bnd_d0", {12'd0, bus.bcd_o}, 16'd1);
    tick(8);
    chk("bnd_d1", {12'd0, bus.bcd_o}, 16'd2);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      tick(2);
      pulse_upd(vecs[i].digits, vecs[i].dp);
      wait_frame();
      cur = 0;
      for (int k = 0; k < 4; k++) begin
        tick(8 * k + 1 - cur);
        cur = 8 * k + 1;
        chk($sformatf("v%0d_d%0d_guard_an", i, k), {12'd0, bus.an_o}, 16'h000F);
        chk($sformatf("v%0d_d%0d_guard_bcd", i, k), {12'd0, bus.bcd_o}, {12'd0, vecs[i].bcd[4*k +: 4]});
        tick(4);
        cur = cur + 4;
        chk($sformatf("v%0d_d%0d_an", i, k),  {12'd0, bus.an_o},   {12'd0, vecs[i].an[4*k +: 4]});
        chk($sformatf("v%0d_d%0d_bcd", i, k), {12'd0, bus.bcd_o},  {12'd0, vecs[i].bcd[4*k +: 4]});
        chk($sformatf("v%0d_d%0d_dpn", i, k), {15'd0, bus.dp_n_o}, {15'd0, vecs[i].dpn[k]});
      end
    end

    // Reset during digit 2 SHOW
    tick(2);
    pulse_upd(16'h1234, 4'b0100);
    wait_frame();
    tick(21);
    chk("pre_rst_an",  {12'd0, bus.an_o},   16'h000B);
    chk("pre_rst_bcd", {12'd0, bus.bcd_o},  16'd2);
    chk("pre_rst_dpn", {15'd0, bus.dp_n_o}, 16'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_an",  {12'd0, bus.an_o},   16'h000F);
    chk("async_rst_bcd", {12'd0, bus.bcd_o},  16'd0);
    chk("async_rst_dpn", {15'd0, bus.dp_n_o}, 16'd1);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    chk("rel2_guard_an", {12'd0, bus.an_o}, 16'h000F);
    tick(1);
    chk("rel2_first_an",  {12'd0, bus.an_o},  16'h000E);
    chk("rel2_first_bcd", {12'd0, bus.bcd_o}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
